scaler_mem_writer: RTL

- Write-side counterpart of the scaler memory readout: loads per-layer scaler words into the 16-entry scaler memory write port from an upstream valid/ready word stream (host/DMA).
- A start pulse programs a base address and a word count. The block accepts exactly that many beats, issues one registered write per beat, then pulses done.
- Sits between the configuration stream and the scaler memory's write port. The read-side controller reads the same memory after load_done.

---
 rtl/scaler_mem_writer_if.sv | 24 ++
 rtl/scaler_mem_writer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/scaler_mem_writer_if.sv
// Bundles the upstream word stream and the scaler memory write port of the
// scaler memory writer. The slave side is the writer; the master side is the
// host/DMA plus memory environment that feeds words and observes writes.
interface scaler_mem_writer_if #(
    parameter int SCALER_WIDTH = 32,
    parameter int ADDR_WIDTH   = 4
);
    logic                    s_valid;
    logic [SCALER_WIDTH-1:0] s_data;
    logic                    s_ready;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [SCALER_WIDTH-1:0] mem_din;

    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_din
    );

    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/scaler_mem_writer.sv
// Scaler memory writer: after a start request with a base address and a word
// count, accepts exactly that many words from the upstream stream and issues
// one registered memory write per accepted word, one cycle after acceptance.
// The address pointer wraps modulo the memory depth. Pulses done with the
// final write; an illegal count raises a sticky error and nothing is written.
module scaler_mem_writer #(
    parameter int SCALER_WIDTH = 32,
    parameter int ADDR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_load_base,
    input  logic [ADDR_WIDTH:0]   i_load_count,
    output logic                  o_load_busy,
    output logic                  o_load_done,
    output logic                  o_load_err,
    scaler_mem_writer_if.slave    bus
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_LEFT  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr_ptr;
    logic [ADDR_WIDTH:0]     r_remaining;
    logic                    r_s_ready;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [SCALER_WIDTH-1:0] r_mem_din;
    logic                    r_load_busy;
    logic                    r_load_done;
    logic                    r_load_err;

    logic w_count_legal;
    logic w_handshake;

    // A count is legal when it names between one word and the full memory.
    assign w_count_legal = (i_load_count != '0) && (i_load_count <= MAX_COUNT);
    // s_ready is only ever high in LOAD, so this is also the in-LOAD accept.
    assign w_handshake   = bus.s_valid && r_s_ready;

    // Load sequencer: start decode, per-beat write issue and completion.
    // NOTE: every register here is assigned with <= so all updates see the
    // values from before the clock edge; blocking assignments would let later
    // statements observe half-updated state and change the pipeline timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr_ptr  <= '0;
            r_remaining <= '0;
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_load_busy <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_load_start) begin
                        if (w_count_legal) begin
                            r_addr_ptr  <= i_load_base;
                            r_remaining <= i_load_count;
                            r_load_err  <= 1'b0;
                            r_s_ready   <= 1'b1;
                            r_load_busy <= 1'b1;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_load_err  <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    // Starts arriving here are deliberately not looked at.
                    if (w_handshake) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr_ptr;
                        r_mem_din   <= bus.s_data;
                        r_addr_ptr  <= r_addr_ptr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - ONE_LEFT;
                        if (r_remaining == ONE_LEFT) begin
                            r_s_ready   <= 1'b0;
                            r_load_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // The final write and done are on the outputs this cycle.
                    r_load_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_s_ready   <= 1'b0;
                    r_load_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_ready  = r_s_ready;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_din  = r_mem_din;
    assign o_load_busy  = r_load_busy;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;

endmodule
